parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a sensor change is accepted.
REQ-002 Parameter BARRIER_CYCLES, default 16: minimum barrier-open time in cycles.
REQ-003 Parameter LOCK_CYCLES, default 64: exit-keypad lockout duration in cycles.
REQ-004 Parameter MAX_FAILS, default 3: consecutive rejected exit codes that trigger lockout.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 enable  in  1  system clock; all state changes occur on its rising edge.
REQ-007 gl_reset  in  1  asynchronous active-low reset.
REQ-008 entry_sensor  in  1  raw, asynchronous car-present sensor at the entry lane.
REQ-009 exit_sensor  in  1  raw, asynchronous car-present sensor at the exit lane.
REQ-010 key_valid  in  1  one-cycle strobe: the exit keypad holds a complete slot/code entry.
REQ-011 key_slot  in  3  slot number entered at the exit keypad (1..7).
REQ-012 key_code  in  8  exit code entered at the exit keypad.
REQ-013 can_park  in  1  lot has a free slot, from the downstream parking core.
REQ-014 exit_ok  in  1  exit code accepted, from the parking core, valid the cycle after car_exit.
REQ-015 car_arrival  out  1  one-cycle arrival request to the parking core.
REQ-016 car_exit  out  1  one-cycle exit request to the parking core.
REQ-017 exit_from  out  3  latched slot; valid only while car_exit=1, 0 otherwise.
REQ-018 exit_code  out  8  latched code; valid only while car_exit=1, 0 otherwise.
REQ-019 entry_barrier_open / exit_barrier_open  out  1 each  barrier actuator drives.
REQ-020 entry_denied / exit_denied  out  1 each  one-cycle rejection pulses.
REQ-021 locked  out  1  high while in the LOCKOUT state.

Function
REQ-022 Each sensor: 2-flop synchroniser, then debounce; the debounced value changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-023 entry_pend is set on a debounced entry_sensor rising edge; further edges are ignored while it is already set.
REQ-024 exit_pend is set on key_valid=1 when exit_pend=0, state!=LOCKOUT and key_slot!=0; key_slot and key_code are latched at the same edge; otherwise key_valid is ignored.
REQ-025 FSM states: IDLE, ENTRY_REQ, ENTRY_OPEN, EXIT_REQ, EXIT_CHECK, EXIT_OPEN, LOCKOUT.
REQ-026 IDLE transitions: exit_pend -> EXIT_REQ (exit has priority over entry); else entry_pend with can_park=1 -> ENTRY_REQ; else entry_pend with can_park=0 -> entry_denied=1 for one cycle, entry_pend cleared, remain in IDLE.
REQ-027 ENTRY_REQ: car_arrival=1 for exactly one cycle, entry_pend cleared, barrier timer loaded with BARRIER_CYCLES, next state ENTRY_OPEN.
REQ-028 ENTRY_OPEN: entry_barrier_open=1, timer decrements to 0 then holds; transition to IDLE when timer=0 and debounced entry_sensor=0 (barrier never closes on a present car).
REQ-029 EXIT_REQ: car_exit=1 with the latched exit_from/exit_code for exactly one cycle, next state EXIT_CHECK.
REQ-030 EXIT_CHECK, exit_pend cleared in all cases: exit_ok=1 -> fail_cnt=0, timer loaded with BARRIER_CYCLES, next state EXIT_OPEN; exit_ok=0 -> exit_denied=1 for one cycle, fail_cnt+1, next state LOCKOUT when the new count equals MAX_FAILS (timer loaded with LOCK_CYCLES), else IDLE.
REQ-031 EXIT_OPEN: identical to ENTRY_OPEN, using exit_sensor and exit_barrier_open.
REQ-032 LOCKOUT: locked=1, key_valid ignored; when the timer reaches 0 -> fail_cnt=0, next state IDLE; entry_pend is held and served afterwards.
REQ-033 Entry edges arriving in any non-IDLE state are captured per REQ-023 and served on a later IDLE visit.
REQ-034 fail_cnt saturates at MAX_FAILS; the timer is wide enough for max(BARRIER_CYCLES, LOCK_CYCLES).

Reset
REQ-035 With gl_reset=0, all outputs are 0, state=IDLE, pend flags, fail_cnt, timer and debounced values are 0, and the synchronisers are cleared; this applies immediately, including mid-transaction.
REQ-036 Operation resumes on the first rising edge of enable after gl_reset returns to 1.

Verification
REQ-037 can_park=1, entry_sensor held high for 10 cycles -> one car_arrival pulse; entry_barrier_open high for at least 16 cycles and until the debounced sensor is 0.
REQ-038 can_park=0, entry edge -> entry_denied for one cycle; no car_arrival; barrier stays closed.
REQ-039 key_slot=6, key_code=8'h35, exit_ok=1 -> car_exit for one cycle with exit_from=6 and exit_code=8'h35; exit_barrier_open follows.
REQ-040 Three key_valid strobes with exit_ok=0 -> three exit_denied pulses, then locked=1 for 64 cycles; a key_valid during lockout produces no car_exit.
REQ-041 Entry edge and key_valid in the same cycle -> car_exit is served first; car_arrival follows after EXIT_OPEN completes.
REQ-042 gl_reset=0 asserted during ENTRY_OPEN -> barrier output drops to 0 asynchronously; no pulse occurs after release.

Source files
------------

// File: rtl/parking_gate_ctrl_if.sv
// Handshake bundle between the gate controller and the downstream parking core.
interface parking_gate_ctrl_if;
  logic       car_arrival;
  logic       car_exit;
  logic [2:0] exit_from;
  logic [7:0] exit_code;
  logic       can_park;
  logic       exit_ok;

  // Gate controller side: issues requests, receives lot status and verdicts.
  modport master (
    output car_arrival, car_exit, exit_from, exit_code,
    input  can_park, exit_ok
  );

  // Parking core side.
  modport slave (
    input  car_arrival, car_exit, exit_from, exit_code,
    output can_park, exit_ok
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking lot gate controller: debounced lane sensors, exit keypad with
// failed-code lockout, and entry/exit barrier sequencing toward the parking core.
module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BARRIER_CYCLES  = 16,
  parameter int LOCK_CYCLES     = 64,
  parameter int MAX_FAILS       = 3
) (
  input  logic                 enable,
  input  logic                 gl_reset,
  input  logic                 entry_sensor,
  input  logic                 exit_sensor,
  input  logic                 key_valid,
  input  logic [2:0]           key_slot,
  input  logic [7:0]           key_code,
  parking_gate_ctrl_if.master  core,
  output logic                 entry_barrier_open,
  output logic                 exit_barrier_open,
  output logic                 entry_denied,
  output logic                 exit_denied,
  output logic                 locked
);

  localparam int TMAX = (BARRIER_CYCLES > LOCK_CYCLES) ? BARRIER_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY_REQ, S_ENTRY_OPEN, S_EXIT_REQ, S_EXIT_CHECK, S_EXIT_OPEN, S_LOCKOUT
  } state_t;

  // Sensor index 0 = entry lane, 1 = exit lane.
  logic [1:0] raw_sensor;
  logic [1:0] deb_q;
  logic [1:0] deb_d;
  assign raw_sensor = {exit_sensor, entry_sensor};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sensor
      logic          sync1_q, sync2_q, stable_q;
      logic [DW-1:0] cnt_q, cnt_d;

      // Accept the synchronised level only once it has disagreed for the full window.
      assign deb_d[gi] = (sync2_q != stable_q && cnt_q == DEB_LAST) ? sync2_q : stable_q;
      assign cnt_d     = (sync2_q == stable_q || cnt_q == DEB_LAST) ? '0 : cnt_q + DW'(1);
      assign deb_q[gi] = stable_q;

      // Two-flop synchroniser followed by the debounce counter.
      always_ff @(posedge enable or negedge gl_reset) begin
        if (!gl_reset) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          sync1_q  <= raw_sensor[gi];
          sync2_q  <= sync1_q;
          cnt_q    <= cnt_d;
          stable_q <= deb_d[gi];
        end
      end
    end
  endgenerate

  // Debounced entry rising edge, seen on the same edge the debounced value flips.
  logic entry_rise;
  assign entry_rise = deb_d[0] & ~deb_q[0];

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic          entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
  logic [2:0]    slot_q, slot_d;
  logic [7:0]    code_q, code_d;
  logic          entry_clr, exit_clr, key_accept;
  logic          arrival_c, exit_c;

  assign fail_inc   = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
  assign key_accept = key_valid && !exit_pend_q && (state_q != S_LOCKOUT) && (key_slot != 3'd0);

  // Pending-request flags and latched keypad entry.
  always_comb begin
    entry_pend_d = entry_clr ? 1'b0 : (entry_rise ? 1'b1 : entry_pend_q);
    exit_pend_d  = exit_clr  ? 1'b0 : (key_accept ? 1'b1 : exit_pend_q);
    slot_d       = key_accept ? key_slot : slot_q;
    code_d       = key_accept ? key_code : code_q;
  end

  // Next-state and output decode; exit requests win over entry in IDLE.
  always_comb begin
    state_d            = state_q;
    timer_d            = timer_q;
    fail_d             = fail_q;
    entry_clr          = 1'b0;
    exit_clr           = 1'b0;
    arrival_c          = 1'b0;
    exit_c             = 1'b0;
    entry_barrier_open = 1'b0;
    exit_barrier_open  = 1'b0;
    entry_denied       = 1'b0;
    exit_denied        = 1'b0;
    locked             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exit_pend_q) begin
          state_d = S_EXIT_REQ;
        end else if (entry_pend_q) begin
          if (core.can_park) begin
            state_d = S_ENTRY_REQ;
          end else begin
            entry_denied = 1'b1;
            entry_clr    = 1'b1;
          end
        end
      end
      S_ENTRY_REQ: begin
        arrival_c = 1'b1;
        entry_clr = 1'b1;
        timer_d   = TW'(BARRIER_CYCLES);
        state_d   = S_ENTRY_OPEN;
      end
      S_ENTRY_OPEN: begin
        entry_barrier_open = 1'b1;
        if (timer_q != '0)  timer_d = timer_q - TW'(1);
        else if (!deb_q[0]) state_d = S_IDLE;
      end
      S_EXIT_REQ: begin
        exit_c  = 1'b1;
        state_d = S_EXIT_CHECK;
      end
      S_EXIT_CHECK: begin
        exit_clr = 1'b1;
        if (core.exit_ok) begin
          fail_d  = '0;
          timer_d = TW'(BARRIER_CYCLES);
          state_d = S_EXIT_OPEN;
        end else begin
          exit_denied = 1'b1;
          fail_d      = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            timer_d = TW'(LOCK_CYCLES);
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_EXIT_OPEN: begin
        exit_barrier_open = 1'b1;
        if (timer_q != '0)  timer_d = timer_q - TW'(1);
        else if (!deb_q[1]) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        // Leave on the edge the timer would reach zero, so locked lasts LOCK_CYCLES.
        locked = 1'b1;
        if (timer_q <= TW'(1)) begin
          timer_d = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge enable or negedge gl_reset) begin
    if (!gl_reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      fail_q       <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      slot_q       <= 3'd0;
      code_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      slot_q       <= slot_d;
      code_q       <= code_d;
    end
  end

  assign core.car_arrival = arrival_c;
  assign core.car_exit    = exit_c;
  assign core.exit_from   = exit_c ? slot_q : 3'd0;
  assign core.exit_code   = exit_c ? code_q : 8'd0;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl; event counters are sampled on the falling edge.
module tb_parking_gate_ctrl;
  logic       enable = 1'b0;
  logic       gl_reset = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic       key_valid = 1'b0;
  logic [2:0] key_slot = 3'd0;
  logic [7:0] key_code = 8'd0;
  logic       entry_barrier_open, exit_barrier_open, entry_denied, exit_denied, locked;

  parking_gate_ctrl_if core_if();

  parking_gate_ctrl dut (
    .enable             (enable),
    .gl_reset           (gl_reset),
    .entry_sensor       (entry_sensor),
    .exit_sensor        (exit_sensor),
    .key_valid          (key_valid),
    .key_slot           (key_slot),
    .key_code           (key_code),
    .core               (core_if),
    .entry_barrier_open (entry_barrier_open),
    .exit_barrier_open  (exit_barrier_open),
    .entry_denied       (entry_denied),
    .exit_denied        (exit_denied),
    .locked             (locked)
  );

  always #5 enable = ~enable;

  int total = 0;
  int passed = 0;

  int cyc = 0;
  int arr_n = 0, exit_n = 0, eopen_n = 0, xopen_n = 0, eden_n = 0, xden_n = 0, lock_n = 0;
  int last_arr = 0, last_exit = 0, last_xopen = 0, last_lock = 0;
  int last_from = 0, last_code = 0;
  int s_arr, s_exit, s_eopen, s_xopen, s_eden, s_xden, s_lock;

  // Event monitor: counts output activity and remembers when it last happened.
  always @(negedge enable) begin
    if (gl_reset) begin
      cyc <= cyc + 1;
      if (core_if.car_arrival) begin arr_n <= arr_n + 1; last_arr <= cyc; end
      if (core_if.car_exit) begin
        exit_n    <= exit_n + 1;
        last_exit <= cyc;
        last_from <= int'(core_if.exit_from);
        last_code <= int'(core_if.exit_code);
      end
      if (entry_barrier_open) eopen_n <= eopen_n + 1;
      if (exit_barrier_open) begin xopen_n <= xopen_n + 1; last_xopen <= cyc; end
      if (entry_denied) eden_n <= eden_n + 1;
      if (exit_denied) xden_n <= xden_n + 1;
      if (locked) begin lock_n <= lock_n + 1; last_lock <= cyc; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge enable);
    #1;
  endtask

  task automatic snap();
    s_arr = arr_n; s_exit = exit_n; s_eopen = eopen_n; s_xopen = xopen_n;
    s_eden = eden_n; s_xden = xden_n; s_lock = lock_n;
  endtask

  task automatic key(input logic [2:0] s, input logic [7:0] c);
    key_slot = s; key_code = c; key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic pulse_entry(input int n);
    entry_sensor = 1'b1;
    step(n);
    entry_sensor = 1'b0;
  endtask

  initial begin
    core_if.can_park = 1'b0;
    core_if.exit_ok  = 1'b0;

    // Reset state.
    step(3);
    check("rst_core_outs", {core_if.car_arrival, core_if.car_exit, core_if.exit_from, core_if.exit_code}, 0);
    check("rst_gate_outs", {entry_barrier_open, exit_barrier_open, entry_denied, exit_denied}, 0);
    check("rst_locked", locked, 0);
    gl_reset = 1'b1;
    step(2);

    // Short entry: barrier open exactly BARRIER_CYCLES+1 cycles.
    core_if.can_park = 1'b1;
    snap();
    pulse_entry(10);
    step(50);
    check("entry_arrivals", arr_n - s_arr, 1);
    check("entry_open_short", eopen_n - s_eopen, 17);
    check("entry_no_deny", eden_n - s_eden, 0);

    // Long presence: barrier held until the debounced sensor clears.
    snap();
    pulse_entry(40);
    step(50);
    check("entry_long_arrivals", arr_n - s_arr, 1);
    check("entry_open_long", eopen_n - s_eopen, 39);

    // Lot full: denied pulse, no arrival, barrier closed.
    core_if.can_park = 1'b0;
    snap();
    pulse_entry(10);
    step(30);
    check("full_denied", eden_n - s_eden, 1);
    check("full_no_arrival", arr_n - s_arr, 0);
    check("full_no_open", eopen_n - s_eopen, 0);
    core_if.can_park = 1'b1;

    // Accepted exit code.
    core_if.exit_ok = 1'b1;
    snap();
    key(3'd6, 8'h35);
    step(40);
    check("exit_pulses", exit_n - s_exit, 1);
    check("exit_from", last_from, 6);
    check("exit_code", last_code, 8'h35);
    check("exit_open", xopen_n - s_xopen, 17);
    check("exit_no_deny", xden_n - s_xden, 0);
    check("exit_from_idle", core_if.exit_from, 0);

    // Slot 0 entries are ignored.
    snap();
    key(3'd0, 8'h44);
    step(20);
    check("slot0_ignored", exit_n - s_exit, 0);

    // Rejected codes: two fails do not lock.
    core_if.exit_ok = 1'b0;
    snap();
    key(3'd2, 8'h11); step(8);
    key(3'd2, 8'h11); step(8);
    check("two_fail_denied", xden_n - s_xden, 2);
    check("two_fail_unlocked", lock_n - s_lock, 0);

    // Third fail locks; keypad ignored and entry deferred during lockout.
    snap();
    key(3'd2, 8'h11); step(8);
    pulse_entry(10);
    key(3'd3, 8'h22);
    step(100);
    check("third_fail_denied", xden_n - s_xden, 1);
    check("lockout_exit_pulses", exit_n - s_exit, 1);
    check("lockout_cycles", lock_n - s_lock, 64);
    check("lockout_entry_served", arr_n - s_arr, 1);
    check("entry_after_lockout", last_arr > last_lock, 1);

    // Fail count cleared after lockout: one more fail does not lock.
    snap();
    key(3'd2, 8'h11); step(8);
    check("post_lock_denied", xden_n - s_xden, 1);
    check("post_lock_unlocked", lock_n - s_lock, 0);

    // Simultaneous entry edge and key: exit served first.
    core_if.exit_ok = 1'b1;
    snap();
    entry_sensor = 1'b1;
    key(3'd5, 8'hA7);
    step(9);
    entry_sensor = 1'b0;
    step(70);
    check("both_exit", exit_n - s_exit, 1);
    check("both_arrival", arr_n - s_arr, 1);
    check("both_exit_code", last_code, 8'hA7);
    check("exit_before_arrival", last_exit < last_arr, 1);
    check("arrival_after_xopen", last_xopen < last_arr, 1);

    // Asynchronous reset during ENTRY_OPEN.
    pulse_entry(10);
    step(12);
    check("pre_reset_open", entry_barrier_open, 1);
    #2 gl_reset = 1'b0;
    #1;
    check("async_reset_drop", entry_barrier_open, 0);
    step(3);
    gl_reset = 1'b1;
    snap();
    step(40);
    check("post_reset_no_arrival", arr_n - s_arr, 0);
    check("post_reset_no_open", eopen_n - s_eopen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
